// File: rtl/siso_shift_ctrl.sv
// Loopback sequencer around a DEPTH-stage SISO shift register: serialises a parallel word and reassembles it.
// Optional feature: define PARITY_EN to append an even-parity bit and report parity_err.
module siso_shift_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             sr_en,
   output logic             sr_din,
   input  logic             sr_dout,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy
`ifdef PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int CW = $clog2(N + DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    c_q, c_d;
   logic [N-1:0]     tx_sr_q, tx_sr_d;
   logic [N-1:0]     rx_sr_q, rx_sr_d;
   logic             tx_ready_q, tx_ready_d;
   logic [WIDTH-1:0] tx_ord;
   logic [WIDTH-1:0] rx_pay;
   logic [N-1:0]     frame;
   logic             capture;

   // Both shift registers always move toward the MSB; bit order is fixed up at the parallel boundary.
   always_comb begin
      tx_ord  = '0;
      rx_data = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (MSB_FIRST != 0) begin
            tx_ord[i]  = tx_data[i];
            rx_data[i] = rx_pay[i];
         end else begin
            tx_ord[i]  = tx_data[WIDTH-1-i];
            rx_data[i] = rx_pay[WIDTH-1-i];
         end
      end
   end

   assign rx_pay = rx_sr_q[N-1 -: WIDTH];

`ifdef PARITY_EN
   assign frame = {tx_ord, ^tx_data};
`else
   assign frame = tx_ord;
`endif

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      tx_sr_d = tx_sr_q;
      rx_sr_d = rx_sr_q;
      // The first DEPTH outputs of a frame are whatever the register held before; skip them.
      capture = ((state_q == RUN) || (state_q == FLUSH)) && (c_q >= CW'(DEPTH));
      if (capture) begin
         rx_sr_d = (rx_sr_q << 1) | N'(sr_dout);
      end
      case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready_q) begin
               tx_sr_d = frame;
               c_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            tx_sr_d = tx_sr_q << 1;
            c_d     = c_q + CW'(1);
            if (c_q == CW'(N - 1)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            c_d = c_q + CW'(1);
            if (c_q == CW'(N + DEPTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rx_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      tx_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         c_q        <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         tx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         c_q        <= c_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         tx_ready_q <= tx_ready_d;
      end
   end

`ifdef PARITY_EN
   logic parity_err_q, parity_err_d;

   // Evaluated once on DONE entry over payload plus parity bit, held until DONE is left.
   always_comb begin
      parity_err_d = parity_err_q;
      if (state_d != DONE) begin
         parity_err_d = 1'b0;
      end else if (state_q == FLUSH) begin
         parity_err_d = ^rx_sr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

   assign tx_ready = tx_ready_q;
   assign sr_en    = (state_q == RUN) || (state_q == FLUSH);
   assign sr_din   = (state_q == RUN) && tx_sr_q[N-1];
   assign rx_valid = (state_q == DONE);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Scoreboard bench: two controllers (MSB-first and LSB-first) each looped through an ideal shift register.
module tb_siso_shift_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int LAT = N + DEPTH;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;

   logic       tx_ready, sr_en, sr_din, sr_dout, rx_valid, busy;
   logic [7:0] rx_data;
   logic       tx_ready_l, sr_en_l, sr_din_l, sr_dout_l, rx_valid_l, busy_l;
   logic [7:0] rx_data_l;
`ifdef PARITY_EN
   logic       perr, perr_l;
`endif

   siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) u_dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .sr_en(sr_en), .sr_din(sr_din), .sr_dout(sr_dout), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy)
`ifdef PARITY_EN
      , .parity_err(perr)
`endif
   );

   siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready_l), .tx_data(tx_data),
      .sr_en(sr_en_l), .sr_din(sr_din_l), .sr_dout(sr_dout_l), .rx_valid(rx_valid_l),
      .rx_ready(rx_ready), .rx_data(rx_data_l), .busy(busy_l)
`ifdef PARITY_EN
      , .parity_err(perr_l)
`endif
   );

   always #5 clk = ~clk;

   // Ideal shift registers, preloaded with ones so stale contents differ from flush zeros.
   logic [DEPTH-1:0] pipe_m = '1;
   logic [DEPTH-1:0] pipe_l = '1;
   always @(posedge clk) begin
      if (sr_en)   pipe_m <= {pipe_m[DEPTH-2:0], sr_din};
      if (sr_en_l) pipe_l <= {pipe_l[DEPTH-2:0], sr_din_l};
   end
   assign sr_dout   = pipe_m[DEPTH-1];
   assign sr_dout_l = pipe_l[DEPTH-1];

   typedef struct { logic [7:0] d; int unsigned cyc; } exp_t;
   exp_t        exp_m[$];
   exp_t        exp_l[$];
   bit          bq_m[$];
   bit          bq_l[$];
   exp_t        e;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned rr_mode = 1;
   logic [7:0]  hold_m = 8'h00, hold_l = 8'h00;
   logic        prev_m = 1'b0, prev_l = 1'b0;
   bit          bq_bit;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Monitor: samples on the falling edge, predicts accepts and pops expectations.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         chk("reset_outputs",
             32'({tx_ready, sr_en, sr_din, rx_valid, busy, rx_data,
                  tx_ready_l, sr_en_l, sr_din_l, rx_valid_l, busy_l, rx_data_l}), 32'(0));
         exp_m.delete(); exp_l.delete(); bq_m.delete(); bq_l.delete();
         prev_m = 1'b0; prev_l = 1'b0; hold_m = 8'h00; hold_l = 8'h00;
      end else begin
         chk("tx_ready_idle", 32'(tx_ready), 32'(!busy));
         if (sr_en) begin
            if (bq_m.size() == 0) chk("unexpected_sr_en", 32'(sr_en), 32'(0));
            else begin bq_bit = bq_m.pop_front(); chk("sr_din_msb", 32'(sr_din), 32'(bq_bit)); end
         end else chk("sr_din_quiet", 32'(sr_din), 32'(0));
         if (sr_en_l) begin
            if (bq_l.size() == 0) chk("unexpected_sr_en_lsb", 32'(sr_en_l), 32'(0));
            else begin bq_bit = bq_l.pop_front(); chk("sr_din_lsb", 32'(sr_din_l), 32'(bq_bit)); end
         end else chk("sr_din_quiet_lsb", 32'(sr_din_l), 32'(0));

         if (rx_valid && !prev_m) begin
            if (exp_m.size() == 0) chk("unexpected_rx_valid", 32'(rx_valid), 32'(0));
            else begin
               e = exp_m.pop_front();
               chk("rx_data_msb", 32'(rx_data), 32'(e.d));
               chk("latency", cyc - e.cyc, 32'(LAT + 1));
               hold_m = e.d;
`ifdef PARITY_EN
               chk("parity_err", 32'(perr), 32'(0));
`endif
            end
         end
         if (rx_valid_l && !prev_l) begin
            if (exp_l.size() == 0) chk("unexpected_rx_valid_lsb", 32'(rx_valid_l), 32'(0));
            else begin
               e = exp_l.pop_front();
               chk("rx_data_lsb", 32'(rx_data_l), 32'(e.d));
               hold_l = e.d;
`ifdef PARITY_EN
               chk("parity_err_lsb", 32'(perr_l), 32'(0));
`endif
            end
         end
         if (rx_valid)   chk("rx_hold",     32'({busy, tx_ready, rx_data}), 32'({1'b1, 1'b0, hold_m}));
         if (rx_valid_l) chk("rx_hold_lsb", 32'({busy_l, tx_ready_l, rx_data_l}), 32'({1'b1, 1'b0, hold_l}));
         if (!busy)   chk("rx_idle_persist",     32'(rx_data), 32'(hold_m));
         if (!busy_l) chk("rx_idle_persist_lsb", 32'(rx_data_l), 32'(hold_l));

         if (tx_valid && tx_ready) begin
            exp_m.push_back('{tx_data, cyc});
            for (int i = WIDTH - 1; i >= 0; i--) bq_m.push_back(tx_data[i]);
`ifdef PARITY_EN
            bq_m.push_back(^tx_data);
`endif
            repeat (DEPTH) bq_m.push_back(1'b0);
         end
         if (tx_valid && tx_ready_l) begin
            exp_l.push_back('{tx_data, cyc});
            for (int i = 0; i < WIDTH; i++) bq_l.push_back(tx_data[i]);
`ifdef PARITY_EN
            bq_l.push_back(^tx_data);
`endif
            repeat (DEPTH) bq_l.push_back(1'b0);
         end
         prev_m = rx_valid;
         prev_l = rx_valid_l;
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send(input logic [7:0] d, input bit keep);
      int unsigned n = 0;
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      while (!tx_ready && n < 300) begin @(negedge clk); n++; end
      if (!tx_ready) chk("send_timeout", 32'(tx_ready), 32'(1));
      if (!keep) begin
         @(posedge clk); #1;
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      @(negedge clk);
      while (busy && n < 1000) begin @(negedge clk); n++; end
      if (busy) chk("idle_timeout", 32'(busy), 32'(0));
   endtask

   int unsigned n;
   logic        seen;

   initial begin
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("tx_ready_after_reset", 32'(tx_ready), 32'(1));

      rr_mode = 1;
      send(8'hB4, 1'b0);
      wait_idle();

      rr_mode = 0;
      send(8'h5A, 1'b0);
      n = 0;
      while (!rx_valid && n < 50) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      chk("bp_held", 32'({rx_valid, tx_ready}), 32'({1'b1, 1'b0}));
      rr_mode = 1;
      n = 0;
      while (rx_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_release", n, 32'(2));
      wait_idle();

      send(8'hFF, 1'b1);
      @(posedge clk); #1;
      tx_data = 8'h01;
      n = 0;
      do begin @(negedge clk); n++; end while (!tx_ready && n < 100);
      chk("b2b_gap", n, 32'(LAT + 2));
      @(posedge clk); #1;
      tx_valid = 1'b0;
      wait_idle();

      rr_mode = 2;
      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(8'($urandom), 1'b0);
      end
      rr_mode = 1;
      wait_idle();

      send(8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      seen = 1'b0;
      repeat (20) begin @(negedge clk); seen = seen | rx_valid | rx_valid_l; end
      chk("no_rx_after_reset", 32'(seen), 32'(0));

      rr_mode = 2;
      for (int k = 0; k < 6; k++) send(8'($urandom), 1'b0);
      rr_mode = 1;
      wait_idle();
      repeat (2) @(negedge clk);
      chk("queues_drained", 32'(exp_m.size() + exp_l.size() + bq_m.size() + bq_l.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
